// File: rtl/ccc_lock_reset_sequencer_if.sv
// Control/status bundle between a PLL lock source and the reset sequencer.
// Master drives lock and software request; slave returns resets and status.
interface ccc_lock_reset_sequencer_if #(
    parameter int unsigned NUM_RST = 4
);
    logic               pll_lock_0;
    logic               sw_rst_req;
    logic [NUM_RST-1:0] rst_out;
    logic               all_ready;
    logic               lock_stable;
    logic [7:0]         lock_loss_cnt;
    logic [1:0]         state;

    modport master (
        output pll_lock_0,
        output sw_rst_req,
        input  rst_out,
        input  all_ready,
        input  lock_stable,
        input  lock_loss_cnt,
        input  state
    );

    modport slave (
        input  pll_lock_0,
        input  sw_rst_req,
        output rst_out,
        output all_ready,
        output lock_stable,
        output lock_loss_cnt,
        output state
    );
endinterface

// File: rtl/ccc_lock_reset_sequencer.sv
// PLL-lock qualifier and staged multi-domain reset sequencer for a PF_CCC.
// Debounces the synchronised lock, releases resets one by one, counts lock losses.
module ccc_lock_reset_sequencer #(
    parameter int unsigned NUM_RST     = 4,
    parameter int unsigned LOCK_FILTER = 1024,
    parameter int unsigned STAGE_DLY   = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    ccc_lock_reset_sequencer_if.slave   bus
);
    // Widths floor at 1 so limits of 1 still give legal vectors.
    localparam int unsigned FiltW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int unsigned DlyW  = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int unsigned IdxW  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [FiltW-1:0] FiltLast = FiltW'(LOCK_FILTER - 1);
    localparam logic [DlyW-1:0]  DlyLast  = DlyW'(STAGE_DLY - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_RST - 1);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StFilter   = 2'd1,
        StRelease  = 2'd2,
        StRun      = 2'd3
    } state_e;

    state_e             st_q;
    logic               sync1_q;
    logic               lock_s_q;
    logic [FiltW-1:0]   filt_q;
    logic [DlyW-1:0]    dly_q;
    logic [IdxW-1:0]    idx_q;
    logic [NUM_RST-1:0] rst_q;
    logic               ready_q;
    logic               stable_q;
    logic [7:0]         loss_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= StWaitLock;
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            filt_q   <= '0;
            dly_q    <= '0;
            idx_q    <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            stable_q <= 1'b0;
            loss_q   <= 8'd0;
        end else begin
            sync1_q  <= bus.pll_lock_0;
            lock_s_q <= sync1_q;
            case (st_q)
                StWaitLock: begin
                    filt_q <= '0;
                    if (lock_s_q) st_q <= StFilter;
                end
                StFilter: begin
                    if (!lock_s_q) begin
                        st_q   <= StWaitLock;
                        filt_q <= '0;
                    end else if (filt_q == FiltLast) begin
                        st_q     <= StRelease;
                        stable_q <= 1'b1;
                        idx_q    <= '0;
                        dly_q    <= '0;
                    end else begin
                        filt_q <= filt_q + FiltW'(1);
                    end
                end
                StRelease, StRun: begin
                    // Lock loss takes priority over a coincident software request.
                    if (!lock_s_q) begin
                        st_q     <= StWaitLock;
                        rst_q    <= '1;
                        ready_q  <= 1'b0;
                        stable_q <= 1'b0;
                        if (loss_q != 8'hff) loss_q <= loss_q + 8'd1;
                    end else if (bus.sw_rst_req) begin
                        st_q    <= StRelease;
                        rst_q   <= '1;
                        ready_q <= 1'b0;
                        idx_q   <= '0;
                        dly_q   <= '0;
                    end else if (st_q == StRelease) begin
                        if (dly_q == DlyLast) begin
                            rst_q[idx_q] <= 1'b0;
                            dly_q        <= '0;
                            idx_q        <= idx_q + IdxW'(1);
                            if (idx_q == IdxLast) begin
                                st_q    <= StRun;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            dly_q <= dly_q + DlyW'(1);
                        end
                    end
                end
                default: st_q <= StWaitLock;
            endcase
        end
    end

    assign bus.rst_out       = rst_q;
    assign bus.all_ready     = ready_q;
    assign bus.lock_stable   = stable_q;
    assign bus.lock_loss_cnt = loss_q;
    assign bus.state         = st_q;
endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// Scoreboard bench: expected output snapshots are queued per edge and checked at negedge.
module tb_ccc_lock_reset_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ccc_lock_reset_sequencer_if #(.NUM_RST(3)) bus ();

    ccc_lock_reset_sequencer #(
        .NUM_RST    (3),
        .LOCK_FILTER(8),
        .STAGE_DLY  (4)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic       stb;
        logic [7:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: values after edge N are compared at the negedge following it.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc < edge_n) begin
                n_fail++;
                $display("FAIL sb_missed: entry for edge %0d seen at edge %0d", e.cyc, edge_n);
            end else if ({bus.rst_out, bus.all_ready, bus.lock_stable, bus.lock_loss_cnt, bus.state}
                         !== {e.rst, e.rdy, e.stb, e.cnt, e.st}) begin
                n_fail++;
                $display("FAIL sb_edge%0d: got rst=%b rdy=%b stb=%b cnt=%0d st=%0d want rst=%b rdy=%b stb=%b cnt=%0d st=%0d",
                         edge_n, bus.rst_out, bus.all_ready, bus.lock_stable, bus.lock_loss_cnt,
                         bus.state, e.rst, e.rdy, e.stb, e.cnt, e.st);
            end
        end
    end

    task automatic push(input int c, input logic [2:0] r, input logic rdy, input logic stb,
                        input logic [7:0] n, input logic [1:0] s);
        exp_t e;
        e.cyc = c; e.rst = r; e.rdy = rdy; e.stb = stb; e.cnt = n; e.st = s;
        sb.push_back(e);
    endtask

    // Expected release profile when the lock is first sampled high at edge b.
    task automatic push_seq(input int b, input logic [7:0] n);
        push(b + 1,  3'b111, 1'b0, 1'b0, n, 2'd0);
        push(b + 2,  3'b111, 1'b0, 1'b0, n, 2'd1);
        push(b + 9,  3'b111, 1'b0, 1'b0, n, 2'd1);
        push(b + 10, 3'b111, 1'b0, 1'b1, n, 2'd2);
        push(b + 13, 3'b111, 1'b0, 1'b1, n, 2'd2);
        push(b + 14, 3'b110, 1'b0, 1'b1, n, 2'd2);
        push(b + 17, 3'b110, 1'b0, 1'b1, n, 2'd2);
        push(b + 18, 3'b100, 1'b0, 1'b1, n, 2'd2);
        push(b + 21, 3'b100, 1'b0, 1'b1, n, 2'd2);
        push(b + 22, 3'b000, 1'b1, 1'b1, n, 2'd3);
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 2000 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: %0d expectations still pending, required 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pll_lock_0 = 1'b0;
        bus.sw_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.rst_out, bus.all_ready, bus.lock_stable, bus.lock_loss_cnt, bus.state}
            !== {3'b111, 1'b0, 1'b0, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got rst=%b rdy=%b stb=%b cnt=%0d st=%0d want 111/0/0/0/0",
                     bus.rst_out, bus.all_ready, bus.lock_stable, bus.lock_loss_cnt, bus.state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lock_release();
        int b;
        b = edge_n + 1;
        push_seq(b, 8'd0);
        bus.pll_lock_0 = 1'b1;
        drain("lock_release");
    endtask

    task automatic test_filter_glitch();
        int b;
        reset = 1'b1;
        bus.pll_lock_0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        b = edge_n + 1;
        push(b + 5, 3'b111, 1'b0, 1'b0, 8'd0, 2'd1);
        push(b + 7, 3'b111, 1'b0, 1'b0, 8'd0, 2'd1);
        push_seq(b + 7, 8'd0);
        bus.pll_lock_0 = 1'b1;
        wait_edge(b + 5);
        bus.pll_lock_0 = 1'b0;
        wait_edge(b + 6);
        bus.pll_lock_0 = 1'b1;
        drain("filter_glitch");
    endtask

    task automatic test_lock_loss();
        int f;
        int g;
        f = edge_n + 1;
        push(f + 1, 3'b000, 1'b1, 1'b1, 8'd0, 2'd3);
        push(f + 2, 3'b111, 1'b0, 1'b0, 8'd1, 2'd0);
        g = f + 5;
        push_seq(g, 8'd1);
        bus.pll_lock_0 = 1'b0;
        wait_edge(g - 1);
        bus.pll_lock_0 = 1'b1;
        drain("lock_loss");
    endtask

    task automatic test_sw_req();
        int s;
        s = edge_n + 1;
        push(s,      3'b111, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 3,  3'b111, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 4,  3'b110, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 8,  3'b100, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 11, 3'b100, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 12, 3'b000, 1'b1, 1'b1, 8'd1, 2'd3);
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        drain("sw_run");

        // Second request lands after bit 0 released: sequence restarts from bit 0.
        s = edge_n + 1;
        push(s,      3'b111, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 5,  3'b110, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 6,  3'b111, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 10, 3'b110, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 14, 3'b100, 1'b0, 1'b1, 8'd1, 2'd2);
        push(s + 18, 3'b000, 1'b1, 1'b1, 8'd1, 2'd3);
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        wait_edge(s + 5);
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        drain("sw_mid_release");
    endtask

    task automatic test_sw_ignored();
        int f;
        int g;
        f = edge_n + 1;
        push(f + 2, 3'b111, 1'b0, 1'b0, 8'd2, 2'd0);
        g = f + 4;
        push_seq(g, 8'd2);
        bus.pll_lock_0 = 1'b0;
        wait_edge(g - 1);
        bus.pll_lock_0 = 1'b1;
        wait_edge(g);
        bus.sw_rst_req = 1'b1;
        wait_edge(g + 1);
        bus.sw_rst_req = 1'b0;
        wait_edge(g + 4);
        bus.sw_rst_req = 1'b1;
        wait_edge(g + 5);
        bus.sw_rst_req = 1'b0;
        drain("sw_ignored");
    endtask

    task automatic test_reset_mid();
        int f;
        int b;
        f = edge_n + 1;
        push(f + 2, 3'b111, 1'b0, 1'b0, 8'd3, 2'd0);
        b = f + 4;
        push(b + 10, 3'b111, 1'b0, 1'b1, 8'd3, 2'd2);
        push(b + 14, 3'b110, 1'b0, 1'b1, 8'd3, 2'd2);
        push(b + 15, 3'b110, 1'b0, 1'b1, 8'd3, 2'd2);
        push(b + 16, 3'b111, 1'b0, 1'b0, 8'd0, 2'd0);
        push_seq(b + 17, 8'd0);
        bus.pll_lock_0 = 1'b0;
        wait_edge(b - 1);
        bus.pll_lock_0 = 1'b1;
        wait_edge(b + 15);
        reset = 1'b1;
        wait_edge(b + 16);
        reset = 1'b0;
        drain("reset_mid");
    endtask

    task automatic test_saturate();
        int b;
        logic [7:0] prev;
        logic [7:0] nxt;
        reset = 1'b1;
        bus.pll_lock_0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            b = edge_n + 1;
            prev = (i > 255) ? 8'd255 : 8'(i);
            nxt  = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            push(b + 10, 3'b111, 1'b0, 1'b1, prev, 2'd2);
            push(b + 13, 3'b111, 1'b0, 1'b0, nxt, 2'd0);
            bus.pll_lock_0 = 1'b1;
            wait_edge(b + 10);
            bus.pll_lock_0 = 1'b0;
            if (i % 50 == 49) begin
                wait_edge(b + 12);
                bus.sw_rst_req = 1'b1;
            end
            wait_edge(b + 13);
            bus.sw_rst_req = 1'b0;
        end
        drain("saturate");
        n_checks++;
        if (bus.lock_loss_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate_final: got cnt=%0d want 255", bus.lock_loss_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock_release();
        test_filter_glitch();
        test_lock_loss();
        test_sw_req();
        test_sw_ignored();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
